// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback, and drives the datapath mux selects, enables and imm_src.
module multicycle_ctrl #(
   parameter bit MEM_WAIT_EN = 1'b1,
   parameter bit TRAP_HALT   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       br_true,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic [2:0] imm_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       illegal,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_EXEC_U   = 4'd4,
      S_MEM_ADDR = 4'd5,
      S_MEM_RD   = 4'd6,
      S_MEM_WB   = 4'd7,
      S_MEM_WR   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LINK     = 4'd12,
      S_ALU_WB   = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   state_t     state_q, state_d;
   logic [2:0] imm_src_q, imm_src_d;
   logic       illegal_q, illegal_d;

   logic       mem_rdy;
   logic       pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;
   logic [1:0] alu_src_a_c, alu_src_b_c, alu_op_c, result_src_c;

   // mem_ready completes the access in the same cycle it is seen high while a
   // strobe is asserted; the FSM holds and keeps the strobe up until then.
   assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

   always_comb begin
      state_d      = state_q;
      imm_src_d    = imm_src_q;
      illegal_d    = illegal_q;
      pc_write_c   = 1'b0;
      ir_write_c   = 1'b0;
      mem_read_c   = 1'b0;
      mem_write_c  = 1'b0;
      reg_write_c  = 1'b0;
      alu_src_a_c  = 2'b00;
      alu_src_b_c  = 2'b00;
      alu_op_c     = 2'b00;
      result_src_c = 2'b00;

      case (state_q)
         S_FETCH: begin
            mem_read_c   = 1'b1;
            alu_src_b_c  = 2'b10;
            result_src_c = 2'b10;
            pc_write_c   = mem_rdy;
            ir_write_c   = mem_rdy;
            if (mem_rdy) state_d = S_DECODE;
         end
         S_DECODE: begin
            // Branch/JAL target is computed here into ALUOut.
            alu_src_b_c = 2'b01;
            case (opcode)
               OP_STORE:         imm_src_d = 3'b001;
               OP_BRANCH:        imm_src_d = 3'b101;
               OP_LUI, OP_AUIPC: imm_src_d = 3'b010;
               OP_JAL:           imm_src_d = 3'b110;
               default:          imm_src_d = 3'b000;
            endcase
            case (opcode)
               OP_R:              state_d = S_EXEC_R;
               OP_I:              state_d = S_EXEC_I;
               OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI, OP_AUIPC:  state_d = S_EXEC_U;
               default: begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_src_a_c = 2'b01;
            alu_op_c    = 2'b10;
            state_d     = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b01;
            alu_op_c    = 2'b10;
            state_d     = S_ALU_WB;
         end
         S_EXEC_U: begin
            alu_src_a_c = (opcode == OP_LUI) ? 2'b10 : 2'b00;
            alu_src_b_c = 2'b01;
            state_d     = S_ALU_WB;
         end
         S_MEM_ADDR: begin
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b01;
            state_d     = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_read_c = 1'b1;
            if (mem_rdy) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write_c  = 1'b1;
            result_src_c = 2'b01;
            state_d      = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write_c = 1'b1;
            if (mem_rdy) state_d = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_c = 2'b01;
            alu_op_c    = 2'b01;
            pc_write_c  = br_true;
            state_d     = S_FETCH;
         end
         S_JAL: begin
            pc_write_c = 1'b1;
            state_d    = S_LINK;
         end
         S_JALR: begin
            alu_src_a_c  = 2'b01;
            alu_src_b_c  = 2'b01;
            result_src_c = 2'b10;
            pc_write_c   = 1'b1;
            state_d      = S_LINK;
         end
         S_LINK: begin
            alu_src_b_c  = 2'b10;
            result_src_c = 2'b10;
            reg_write_c  = 1'b1;
            state_d      = S_FETCH;
         end
         S_ALU_WB: begin
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_TRAP: begin
            illegal_d = 1'b1;
            state_d   = TRAP_HALT ? S_TRAP : S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         imm_src_q <= 3'b000;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         imm_src_q <= imm_src_d;
         illegal_q <= illegal_d;
      end
   end

   // Reset suppresses every write so an aborted instruction leaves no trace.
   assign pc_write   = pc_write_c  & ~rst;
   assign ir_write   = ir_write_c  & ~rst;
   assign mem_read   = mem_read_c  & ~rst;
   assign mem_write  = mem_write_c & ~rst;
   assign reg_write  = reg_write_c & ~rst;
   assign alu_src_a  = rst ? 2'b00 : alu_src_a_c;
   assign alu_src_b  = rst ? 2'b00 : alu_src_b_c;
   assign alu_op     = rst ? 2'b00 : alu_op_c;
   assign result_src = rst ? 2'b00 : result_src_c;
   assign imm_src    = imm_src_q;
   assign illegal    = illegal_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected state/output traces built
// from instruction class, compared every cycle on a halting and a non-halting trap DUT.
module tb_multicycle_ctrl;

   localparam int W = 21;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic       br_true;
   logic       mem_ready;

   logic       h_pc, h_ir, h_rd, h_wr, h_rw, h_ill;
   logic [2:0] h_imm;
   logic [1:0] h_a, h_b, h_op, h_res;
   logic [3:0] h_st;
   logic       n_pc, n_ir, n_rd, n_wr, n_rw, n_ill;
   logic [2:0] n_imm;
   logic [1:0] n_a, n_b, n_op, n_res;
   logic [3:0] n_st;

   multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .TRAP_HALT(1'b1)) dut_h (
      .clk(clk), .rst(rst), .opcode(opcode), .br_true(br_true), .mem_ready(mem_ready),
      .pc_write(h_pc), .ir_write(h_ir), .mem_read(h_rd), .mem_write(h_wr),
      .reg_write(h_rw), .imm_src(h_imm), .alu_src_a(h_a), .alu_src_b(h_b),
      .alu_op(h_op), .result_src(h_res), .illegal(h_ill), .state_o(h_st)
   );

   multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .TRAP_HALT(1'b0)) dut_nh (
      .clk(clk), .rst(rst), .opcode(opcode), .br_true(br_true), .mem_ready(mem_ready),
      .pc_write(n_pc), .ir_write(n_ir), .mem_read(n_rd), .mem_write(n_wr),
      .reg_write(n_rw), .imm_src(n_imm), .alu_src_a(n_a), .alu_src_b(n_b),
      .alu_op(n_op), .result_src(n_res), .illegal(n_ill), .state_o(n_st)
   );

   wire [W-1:0] obs_h  = {h_st, h_pc, h_ir, h_rd, h_wr, h_rw, h_a, h_b, h_op, h_res, h_imm, h_ill};
   wire [W-1:0] obs_nh = {n_st, n_pc, n_ir, n_rd, n_wr, n_rw, n_a, n_b, n_op, n_res, n_imm, n_ill};

   // Clock
   always #5 clk = ~clk;

   // Scoreboard: one expected output vector and one mem_ready value per cycle
   logic [W-1:0] exp_q[$];
   logic         mr_q[$];
   logic [2:0]   m_imm;
   logic         m_ill;
   int           n_tests = 0;
   int           n_fail  = 0;

   logic [6:0] legal_ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] imm_of(input logic [6:0] op);
      case (op)
         7'b0100011:             return 3'b001;
         7'b1100011:             return 3'b101;
         7'b0110111, 7'b0010111: return 3'b010;
         7'b1101111:             return 3'b110;
         default:                return 3'b000;
      endcase
   endfunction

   // Output table per state, straight from the control description
   function automatic logic [W-1:0] pack_exp(input int s, input logic mr, input logic br,
                                             input logic [6:0] op, input logic rs,
                                             input logic [2:0] imm, input logic ill);
      logic pc, ir, rd, wr, rw;
      logic [1:0] a, b, alu, res;
      {pc, ir, rd, wr, rw} = 5'b0;
      a = 2'd0; b = 2'd0; alu = 2'd0; res = 2'd0;
      case (s)
         0:  begin rd = 1'b1; b = 2'd2; res = 2'd2; pc = mr; ir = mr; end
         1:  b = 2'd1;
         2:  begin a = 2'd1; alu = 2'd2; end
         3:  begin a = 2'd1; b = 2'd1; alu = 2'd2; end
         4:  begin a = (op == 7'b0110111) ? 2'd2 : 2'd0; b = 2'd1; end
         5:  begin a = 2'd1; b = 2'd1; end
         6:  rd = 1'b1;
         7:  begin rw = 1'b1; res = 2'd1; end
         8:  wr = 1'b1;
         9:  begin a = 2'd1; alu = 2'd1; pc = br; end
         10: pc = 1'b1;
         11: begin a = 2'd1; b = 2'd1; res = 2'd2; pc = 1'b1; end
         12: begin b = 2'd2; res = 2'd2; rw = 1'b1; end
         13: rw = 1'b1;
         default: ;
      endcase
      if (rs) begin
         {pc, ir, rd, wr, rw} = 5'b0;
         a = 2'd0; b = 2'd0; alu = 2'd0; res = 2'd0;
      end
      return {4'(s), pc, ir, rd, wr, rw, a, b, alu, res, imm, ill};
   endfunction

   // Queue the expected trace of one instruction. wfix<0: random waits in memory states.
   task automatic queue_instr(input logic [6:0] op, input logic br, input int wfix);
      int seq[$];
      int w;
      logic mr;
      case (op)
         7'b0110011:             seq = {0, 1, 2, 13};
         7'b0010011:             seq = {0, 1, 3, 13};
         7'b0110111, 7'b0010111: seq = {0, 1, 4, 13};
         7'b0000011:             seq = {0, 1, 5, 6, 7};
         7'b0100011:             seq = {0, 1, 5, 8};
         7'b1100011:             seq = {0, 1, 9};
         7'b1101111:             seq = {0, 1, 10, 12};
         7'b1100111:             seq = {0, 1, 11, 12};
         default:                seq = {0, 1, 14};
      endcase
      for (int i = 0; i < seq.size(); i++) begin
         if (seq[i] == 0 || seq[i] == 6 || seq[i] == 8)
            w = (wfix >= 0) ? wfix : int'($urandom_range(0, 2));
         else
            w = 0;
         if (seq[i] == 14) m_ill = 1'b1;
         for (int k = 0; k <= w; k++) begin
            if (seq[i] == 14)      mr = 1'b0;
            else if (w > 0 || seq[i] == 0 || seq[i] == 6 || seq[i] == 8) mr = (k == w);
            else                   mr = 1'($urandom_range(0, 1));
            exp_q.push_back(pack_exp(seq[i], mr, br, op, 1'b0,
                                     (i >= 2) ? imm_of(op) : m_imm, m_ill));
            mr_q.push_back(mr);
         end
      end
      m_imm = imm_of(op);
   endtask

   // Driver: apply each queued cycle at negedge and compare both DUTs
   task automatic run_instr(input logic [6:0] op, input logic br, input int wfix);
      logic [W-1:0] e;
      opcode  = op;
      br_true = br;
      queue_instr(op, br, wfix);
      while (exp_q.size() > 0) begin
         mem_ready = mr_q.pop_front();
         e = exp_q.pop_front();
         #1;
         check_eq("trace_h", 32'(obs_h), 32'(e));
         check_eq("trace_nh", 32'(obs_nh), 32'(e));
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic step(input logic mr);
      mem_ready = mr;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; opcode = 7'd0; br_true = 1'b0; mem_ready = 1'b0;
      m_imm = 3'b000; m_ill = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_eq("reset_h", 32'(obs_h), 32'(pack_exp(0, 0, 0, 7'd0, 1'b1, 3'b000, 1'b0)));
      check_eq("reset_nh", 32'(obs_nh), 32'(pack_exp(0, 0, 0, 7'd0, 1'b1, 3'b000, 1'b0)));
      rst = 1'b0;

      // Reset in the middle of a store wait
      opcode = 7'b0100011; br_true = 1'b0;
      step(1'b1); step(1'b1); step(1'b1);
      #1;
      check_eq("memwr_wait", 32'(obs_h), 32'(pack_exp(8, 0, 0, opcode, 1'b0, 3'b001, 1'b0)));
      step(1'b0);
      rst = 1'b1;
      #1;
      check_eq("rst_in_memwr", 32'(obs_h), 32'(pack_exp(8, 0, 0, opcode, 1'b1, 3'b001, 1'b0)));
      step(1'b0);
      #1;
      check_eq("rst_2nd_cycle", 32'(obs_h), 32'(pack_exp(0, 0, 0, opcode, 1'b1, 3'b000, 1'b0)));
      step(1'b0);
      rst = 1'b0;
      m_imm = 3'b000;

      // Directed instruction classes
      run_instr(7'b0000011, 1'b0, 0);
      run_instr(7'b0100011, 1'b0, 3);
      run_instr(7'b1100011, 1'b0, 0);
      run_instr(7'b1100011, 1'b1, 0);
      run_instr(7'b1101111, 1'b0, 0);
      run_instr(7'b1100111, 1'b0, 0);
      run_instr(7'b0110111, 1'b1, 0);
      run_instr(7'b0010111, 1'b0, 1);
      run_instr(7'b0110011, 1'b0, 0);
      run_instr(7'b0010011, 1'b1, 2);

      // Random legal instructions with random memory waits
      for (int i = 0; i < 150; i++)
         run_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), -1);

      // Illegal opcodes: the halting DUT parks, the other returns to FETCH
      for (int t = 0; t < 2; t++) begin
         logic [6:0] bad;
         bad = (t == 0) ? 7'b1111111 : 7'b0001011;
         run_instr(bad, 1'b0, -1);
         for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("trap_hold_h", 32'(obs_h), 32'(pack_exp(14, 0, 0, bad, 1'b0, 3'b000, 1'b1)));
            check_eq("trap_back_nh", 32'(obs_nh), 32'(pack_exp(0, 0, 0, bad, 1'b0, 3'b000, 1'b1)));
            step(1'b0);
         end
         rst = 1'b1;
         step(1'b0);
         rst = 1'b0;
         m_imm = 3'b000;
         m_ill = 1'b0;
         run_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
